// File: rtl/ps_acp_burst_wr_pkg.sv
// ps_acp_pkg: shared AXI constants, FSM state encoding and a constant log2 helper
package ps_acp_pkg;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/ps_acp_burst_wr_wbeat_gen.sv
// ps_acp_wbeat_gen: W-channel beat counter, wvalid/wlast generation and FWFT pop strobe
module ps_acp_wbeat_gen
    import ps_acp_pkg::*;
#(
    parameter int BURST_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_wready,
    output logic o_wvalid,
    output logic o_wlast,
    output logic o_wdreq,
    output logic o_last_hs
);
    localparam int CW = clog2(BURST_LEN + 1);

    logic [CW-1:0] r_cnt;
    logic          r_wvalid;
    logic          r_wlast;
    logic          w_hs;

    assign w_hs      = r_wvalid & i_wready;
    assign o_wvalid  = r_wvalid;
    assign o_wlast   = r_wlast;
    assign o_wdreq   = w_hs;
    assign o_last_hs = w_hs & r_wlast;

    // wvalid stays up from start until the wlast handshake; wlast is armed one beat ahead
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
        end else if (i_start) begin
            r_cnt    <= '0;
            r_wvalid <= 1'b1;
            r_wlast  <= (BURST_LEN == 1);
        end else if (w_hs) begin
            r_cnt    <= r_wlast ? '0 : r_cnt + CW'(1);
            r_wvalid <= ~r_wlast;
            r_wlast  <= ~r_wlast & (r_cnt == CW'(BURST_LEN - 2));
        end
    end
endmodule

// File: rtl/ps_acp_burst_wr.sv
// ps_acp_burst_wr: AXI3 INCR burst write master for the Zynq ACP port; ACP_BRESP_CHECK_EN enables B-response checking
module ps_acp_burst_wr
    import ps_acp_pkg::*;
#(
    parameter int         DATA_W    = 64,
    parameter int         ID_W      = 3,
    parameter int         BURST_LEN = 16,
    parameter logic [3:0] AWCACHE   = 4'b1111,
    parameter logic [4:0] AWUSER    = 5'b00001
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tx_en,
    output logic                tx_rdy,
    input  logic [31:0]         tx_awaddr,
    input  logic [ID_W-1:0]     tx_awid,
    input  logic [DATA_W-1:0]   tx_wdata,
    output logic                tx_wdreq,
    output logic                tx_done,
    output logic                tx_err,
    output logic [31:0]         S_AXI_ACP_0_awaddr,
    output logic [ID_W-1:0]     S_AXI_ACP_0_awid,
    output logic                S_AXI_ACP_0_awvalid,
    input  logic                S_AXI_ACP_0_awready,
    output logic [3:0]          S_AXI_ACP_0_awlen,
    output logic [2:0]          S_AXI_ACP_0_awsize,
    output logic [1:0]          S_AXI_ACP_0_awburst,
    output logic [3:0]          S_AXI_ACP_0_awcache,
    output logic [4:0]          S_AXI_ACP_0_awuser,
    output logic [1:0]          S_AXI_ACP_0_awlock,
    output logic [2:0]          S_AXI_ACP_0_awprot,
    output logic [3:0]          S_AXI_ACP_0_awqos,
    output logic [DATA_W-1:0]   S_AXI_ACP_0_wdata,
    output logic [ID_W-1:0]     S_AXI_ACP_0_wid,
    output logic [DATA_W/8-1:0] S_AXI_ACP_0_wstrb,
    output logic                S_AXI_ACP_0_wlast,
    output logic                S_AXI_ACP_0_wvalid,
    input  logic                S_AXI_ACP_0_wready,
    input  logic [ID_W-1:0]     S_AXI_ACP_0_bid,
    input  logic [1:0]          S_AXI_ACP_0_bresp,
    input  logic                S_AXI_ACP_0_bvalid,
    output logic                S_AXI_ACP_0_bready
);
    localparam int SIZE = clog2(DATA_W / 8);
    localparam int LSB  = clog2(BURST_LEN * DATA_W / 8);

    state_t          r_state;
    logic            r_tx_rdy;
    logic            r_tx_done;
    logic            r_awvalid;
    logic [31:0]     r_awaddr;
    logic [ID_W-1:0] r_awid;
    logic            w_start;
    logic            w_last_hs;

    assign w_start = r_awvalid & S_AXI_ACP_0_awready;

    ps_acp_wbeat_gen #(.BURST_LEN(BURST_LEN)) u_wbeat (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_wready  (S_AXI_ACP_0_wready),
        .o_wvalid  (S_AXI_ACP_0_wvalid),
        .o_wlast   (S_AXI_ACP_0_wlast),
        .o_wdreq   (tx_wdreq),
        .o_last_hs (w_last_hs)
    );

    assign tx_rdy              = r_tx_rdy;
    assign tx_done             = r_tx_done;
    assign S_AXI_ACP_0_awaddr  = r_awaddr;
    assign S_AXI_ACP_0_awid    = r_awid;
    assign S_AXI_ACP_0_awvalid = r_awvalid;
    assign S_AXI_ACP_0_awlen   = 4'(BURST_LEN - 1);
    assign S_AXI_ACP_0_awsize  = 3'(SIZE);
    assign S_AXI_ACP_0_awburst = BURST_INCR;
    assign S_AXI_ACP_0_awcache = AWCACHE;
    assign S_AXI_ACP_0_awuser  = AWUSER;
    assign S_AXI_ACP_0_awlock  = 2'b00;
    assign S_AXI_ACP_0_awprot  = 3'b000;
    assign S_AXI_ACP_0_awqos   = 4'b0000;
    assign S_AXI_ACP_0_wdata   = tx_wdata;
    assign S_AXI_ACP_0_wid     = r_awid;
    assign S_AXI_ACP_0_wstrb   = '1;

`ifdef ACP_BRESP_CHECK_EN
    logic r_bready;
    logic r_tx_err;
    assign S_AXI_ACP_0_bready = r_bready;
    assign tx_err             = r_tx_err;
`else
    logic w_unused_b;
    assign w_unused_b         = &{1'b0, S_AXI_ACP_0_bid, S_AXI_ACP_0_bresp, S_AXI_ACP_0_bvalid};
    assign S_AXI_ACP_0_bready = 1'b1;
    assign tx_err             = 1'b0;
`endif

    // burst sequencer: accept request, issue AW, wait for W completion, then optional B check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_tx_rdy  <= 1'b1;
            r_tx_done <= 1'b0;
            r_awvalid <= 1'b0;
            r_awaddr  <= '0;
            r_awid    <= '0;
`ifdef ACP_BRESP_CHECK_EN
            r_bready  <= 1'b0;
            r_tx_err  <= 1'b0;
`endif
        end else begin
            r_tx_done <= 1'b0;
`ifdef ACP_BRESP_CHECK_EN
            r_tx_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: if (tx_en) begin
                    r_awaddr  <= tx_awaddr & ~((32'd1 << LSB) - 32'd1);
                    r_awid    <= tx_awid;
                    r_tx_rdy  <= 1'b0;
                    r_awvalid <= 1'b1;
                    r_state   <= S_ADDR;
                end
                S_ADDR: if (S_AXI_ACP_0_awready) begin
                    r_awvalid <= 1'b0;
                    r_state   <= S_DATA;
                end
                S_DATA: if (w_last_hs) begin
`ifdef ACP_BRESP_CHECK_EN
                    r_bready  <= 1'b1;
                    r_state   <= S_RESP;
`else
                    r_tx_done <= 1'b1;
                    r_tx_rdy  <= 1'b1;
                    r_state   <= S_IDLE;
`endif
                end
`ifdef ACP_BRESP_CHECK_EN
                S_RESP: if (S_AXI_ACP_0_bvalid) begin
                    r_bready  <= 1'b0;
                    r_tx_done <= 1'b1;
                    r_tx_err  <= (S_AXI_ACP_0_bresp != RESP_OKAY) | (S_AXI_ACP_0_bid != r_awid);
                    r_tx_rdy  <= 1'b1;
                    r_state   <= S_IDLE;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps_acp_burst_wr.sv
// tb_ps_acp_burst_wr: directed and randomized checks of ps_acp_burst_wr against a behavioural burst model
module tb_ps_acp_burst_wr;
    localparam int L = 16;
`ifdef ACP_BRESP_CHECK_EN
    localparam int RESP_CYC = 1;
`else
    localparam int RESP_CYC = 0;
`endif

    logic        clk, rst;
    logic        tx_en, tx_rdy, tx_wdreq, tx_done, tx_err;
    logic [31:0] tx_awaddr, awaddr;
    logic [2:0]  tx_awid, awid, wid, bid, awsize, awprot;
    logic [63:0] tx_wdata, wdata;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]  awlen, awcache, awqos;
    logic [1:0]  awburst, awlock, bresp;
    logic [4:0]  awuser;
    logic [7:0]  wstrb;

    logic        b_tx_en, b_tx_rdy, b_tx_wdreq, b_tx_done, b_tx_err;
    logic [31:0] b_tx_awaddr, b_awaddr, b_tx_wdata, b_wdata;
    logic [2:0]  b_tx_awid, b_awid, b_wid, b_awsize, b_awprot;
    logic        b_awvalid, b_wlast, b_wvalid, b_bready;
    logic [3:0]  b_awlen, b_awcache, b_awqos, b_wstrb;
    logic [1:0]  b_awburst, b_awlock;
    logic [4:0]  b_awuser;

    int passed = 0;
    int total  = 0;

    ps_acp_burst_wr dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .tx_rdy(tx_rdy), .tx_awaddr(tx_awaddr), .tx_awid(tx_awid),
        .tx_wdata(tx_wdata), .tx_wdreq(tx_wdreq), .tx_done(tx_done), .tx_err(tx_err),
        .S_AXI_ACP_0_awaddr(awaddr), .S_AXI_ACP_0_awid(awid), .S_AXI_ACP_0_awvalid(awvalid),
        .S_AXI_ACP_0_awready(awready), .S_AXI_ACP_0_awlen(awlen), .S_AXI_ACP_0_awsize(awsize),
        .S_AXI_ACP_0_awburst(awburst), .S_AXI_ACP_0_awcache(awcache), .S_AXI_ACP_0_awuser(awuser),
        .S_AXI_ACP_0_awlock(awlock), .S_AXI_ACP_0_awprot(awprot), .S_AXI_ACP_0_awqos(awqos),
        .S_AXI_ACP_0_wdata(wdata), .S_AXI_ACP_0_wid(wid), .S_AXI_ACP_0_wstrb(wstrb),
        .S_AXI_ACP_0_wlast(wlast), .S_AXI_ACP_0_wvalid(wvalid), .S_AXI_ACP_0_wready(wready),
        .S_AXI_ACP_0_bid(bid), .S_AXI_ACP_0_bresp(bresp), .S_AXI_ACP_0_bvalid(bvalid),
        .S_AXI_ACP_0_bready(bready)
    );

    ps_acp_burst_wr #(.DATA_W(32), .BURST_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .tx_en(b_tx_en), .tx_rdy(b_tx_rdy), .tx_awaddr(b_tx_awaddr), .tx_awid(b_tx_awid),
        .tx_wdata(b_tx_wdata), .tx_wdreq(b_tx_wdreq), .tx_done(b_tx_done), .tx_err(b_tx_err),
        .S_AXI_ACP_0_awaddr(b_awaddr), .S_AXI_ACP_0_awid(b_awid), .S_AXI_ACP_0_awvalid(b_awvalid),
        .S_AXI_ACP_0_awready(1'b1), .S_AXI_ACP_0_awlen(b_awlen), .S_AXI_ACP_0_awsize(b_awsize),
        .S_AXI_ACP_0_awburst(b_awburst), .S_AXI_ACP_0_awcache(b_awcache), .S_AXI_ACP_0_awuser(b_awuser),
        .S_AXI_ACP_0_awlock(b_awlock), .S_AXI_ACP_0_awprot(b_awprot), .S_AXI_ACP_0_awqos(b_awqos),
        .S_AXI_ACP_0_wdata(b_wdata), .S_AXI_ACP_0_wid(b_wid), .S_AXI_ACP_0_wstrb(b_wstrb),
        .S_AXI_ACP_0_wlast(b_wlast), .S_AXI_ACP_0_wvalid(b_wvalid), .S_AXI_ACP_0_wready(1'b1),
        .S_AXI_ACP_0_bid(3'd2), .S_AXI_ACP_0_bresp(2'b00), .S_AXI_ACP_0_bvalid(1'b1),
        .S_AXI_ACP_0_bready(b_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // one burst: model expects masked address, source words in order, wlast on word L,
    // and completion 2+L(+1 with B check) cycles after request plus one per stall cycle
    task automatic burst(input logic [31:0] a, input logic [2:0] id, input int aw_stall, input int wmode,
                         input logic [1:0] rsp, input logic [2:0] rid, input int rst_beat);
        logic [63:0] src [L];
        logic [31:0] exp_addr;
        logic        exp_err, err_d, rdy_d;
        int t, beats, aw_cnt, aw_st, w_st, done_t, first_aw;
        int bad_data, bad_last, bad_aw, bad_req, gap;
        for (int i = 0; i < L; i++) src[i] = {$urandom, $urandom};
        exp_addr = a - (a % (L * 8));
        exp_err  = (RESP_CYC == 1) && (rsp != 2'b00 || rid != id);
        {t, beats, aw_cnt, aw_st, w_st, bad_data, bad_last, bad_aw, bad_req, gap} = '0;
        done_t = -1; first_aw = -1; err_d = 1'b0; rdy_d = 1'b0;
        bresp = rsp; bid = rid; bvalid = 1'b1;
        check("rdy_before_req", 64'(tx_rdy), 64'd1);
        tx_awaddr = a; tx_awid = id; tx_en = 1'b1;
        @(posedge clk); #1;
        tx_en = 1'b0; tx_awaddr = $urandom; tx_awid = 3'($urandom);
        t = 1;
        while (t < 300) begin
            awready  = awvalid && (aw_cnt >= aw_stall);
            wready   = (wmode == 0) ? 1'b1 : (wmode == 1) ? ((t % 2) == 0) : 1'($urandom % 2);
            tx_wdata = src[beats < L ? beats : 0];
            #1;
            if (awvalid) begin
                if (first_aw < 0) first_aw = t;
                aw_cnt++;
                if (!awready) aw_st++;
                if (awaddr !== exp_addr || awid !== id) bad_aw++;
            end
            if (tx_wdreq !== (wvalid && wready)) bad_req++;
            if (beats > 0 && beats < L && !wvalid) gap++;
            if (wvalid && !wready) w_st++;
            if (rst_beat >= 0 && wvalid && beats == rst_beat) begin
                #1 rst = 1'b1;
                #1;
                check("rst_awvalid", 64'(awvalid), 64'd0);
                check("rst_wvalid", 64'(wvalid), 64'd0);
                check("rst_wlast", 64'(wlast), 64'd0);
                check("rst_tx_rdy", 64'(tx_rdy), 64'd1);
                #1 rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
            if (wvalid && wready) begin
                if (wdata !== src[beats] || wid !== id) bad_data++;
                if (wlast !== (beats == L - 1)) bad_last++;
                if (beats == L - 1) check("last_wdata", wdata, src[L-1]);
                beats++;
            end
            if (tx_done) begin
                done_t = t; err_d = tx_err; rdy_d = tx_rdy;
                break;
            end
            @(posedge clk); #1;
            t++;
        end
        awready = 1'b0; wready = 1'b0;
        check("first_awvalid_cycle", 64'(first_aw), 64'd1);
        check("aw_payload_stable", 64'(bad_aw), 64'd0);
        check("beat_count", 64'(beats), 64'(L));
        check("wdata_order", 64'(bad_data), 64'd0);
        check("wlast_position", 64'(bad_last), 64'd0);
        check("wdreq_strobe", 64'(bad_req), 64'd0);
        check("wvalid_gap", 64'(gap), 64'd0);
        check("done_cycle", 64'(done_t), 64'(2 + L + RESP_CYC + aw_st + w_st));
        check("tx_err", 64'(err_d), 64'(exp_err));
        check("rdy_with_done", 64'(rdy_d), 64'd1);
        @(posedge clk); #1;
        check("done_one_cycle", 64'(tx_done), 64'd0);
    endtask

    initial begin
        int prev, ndone, bad1, bl1_period;
        logic [31:0] ra;
        rst = 1'b1; tx_en = 1'b0; tx_awaddr = '0; tx_awid = '0; tx_wdata = '0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        b_tx_en = 1'b0; b_tx_awaddr = 32'h0000_1237; b_tx_awid = 3'd2; b_tx_wdata = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx_rdy", 64'(tx_rdy), 64'd1);
        check("reset_awvalid", 64'(awvalid), 64'd0);
        check("reset_wvalid", 64'(wvalid), 64'd0);
        check("reset_wlast", 64'(wlast), 64'd0);
        check("reset_done_err", 64'({tx_done, tx_err}), 64'd0);
        check("reset_awaddr", 64'(awaddr), 64'd0);
        check("reset_awid", 64'(awid), 64'd0);
        check("reset_bready", 64'(bready), 64'(RESP_CYC == 0));
        rst = 1'b0;
        @(posedge clk); #1;
        check("awlen", 64'(awlen), 64'd15);
        check("awsize", 64'(awsize), 64'd3);
        check("awburst", 64'(awburst), 64'd1);
        check("awcache_awuser", 64'({awcache, awuser}), 64'({4'b1111, 5'b00001}));
        check("lock_prot_qos", 64'({awlock, awprot, awqos}), 64'd0);
        check("wstrb", 64'(wstrb), 64'hFF);

        burst(32'h1000_0000, 3'd3, 0, 0, 2'b00, 3'd3, -1);
        burst(32'h2000_0040, 3'd3, 5, 1, 2'b00, 3'd3, -1);
        burst(32'h0000_0F48, 3'd3, 0, 0, 2'b00, 3'd3, -1);
        burst(32'h0000_1000, 3'd3, 0, 0, 2'b10, 3'd3, -1);
        burst(32'h0000_2000, 3'd3, 0, 0, 2'b00, 3'd5, -1);
        for (int k = 0; k < 8; k++) begin
            ra = $urandom;
            burst(ra, 3'($urandom), int'($urandom_range(0, 4)), 2, 2'($urandom), 3'($urandom), -1);
        end
        burst(32'h3000_0000, 3'd1, 2, 0, 2'b00, 3'd1, 7);
        burst(32'h4000_0088, 3'd6, 1, 2, 2'b00, 3'd6, -1);

        bl1_period = 3 + RESP_CYC;
        prev = -1; ndone = 0; bad1 = 0;
        b_tx_en = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #2;
            if (b_wvalid && !b_wlast) bad1++;
            if (b_awvalid && b_awaddr !== 32'h0000_1234) bad1++;
            if (b_tx_done) begin
                if (prev >= 0 && t - prev != bl1_period) bad1++;
                if (!b_tx_rdy) bad1++;
                prev = t;
                ndone++;
            end
        end
        b_tx_en = 1'b0;
        check("bl1_back_to_back", 64'(bad1), 64'd0);
        check("bl1_burst_count", 64'(ndone >= 40 / bl1_period - 1), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ps_acp_burst_wr.md
# ps_acp_burst_wr

Parametrised AXI3 write master for the Zynq PS ACP slave port, generalising the fixed single-burst ACP transmitter. It takes one burst request (address, ID) from the local datapath, pulls `BURST_LEN` beats from a first-word-fall-through (FWFT) source, and drives a full INCR burst. It optionally waits for and checks the B response, then reports completion and error status upstream.

## Interface
- `DATA_W`, 64: data width; legal values are 32 and 64.
- `ID_W`, 3: AXI ID width.
- `BURST_LEN`, 16: beats per burst, 1..16; `awlen = BURST_LEN-1`.
- `AWCACHE`, 4'b1111: constant `awcache`.
- `AWUSER`, 5'b00001: constant `awuser`; bit 0 selects a coherent (shared) write.
- `clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-high reset.
- `tx_en` in 1: burst request, sampled only while `tx_rdy`=1.
- `tx_rdy` out 1: idle, ready to accept a request.
- `tx_awaddr` in 32: burst start address.
- `tx_awid` in `ID_W`: burst ID.
- `tx_wdata` in `DATA_W`: current FWFT head word.
- `tx_wdreq` out 1: pop strobe for the FWFT source; equals `wvalid & wready`.
- `tx_done` out 1: one-cycle pulse when the burst completes.
- `tx_err` out 1: valid only with `tx_done`; 1 means the response was bad.
- `S_AXI_ACP_0_awaddr/awid/awvalid` out: AW payload and valid.
- `S_AXI_ACP_0_awready` in 1: AW ready.
- `S_AXI_ACP_0_awlen/awsize/awburst/awcache/awuser/awlock/awprot/awqos` out: constant AW fields.
- `S_AXI_ACP_0_wdata/wid/wstrb/wlast/wvalid` out: W channel.
- `S_AXI_ACP_0_wready` in 1: W ready.
- `S_AXI_ACP_0_bid/bresp/bvalid` in; `S_AXI_ACP_0_bready` out: B channel.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- Reset: FSM enters IDLE. Outputs reset to `tx_rdy`=1 and all of the following 0: `awvalid`, `wvalid`, `wlast`, `bready`, `tx_done`, `tx_err`, `awaddr`, `awid`, beat counter.
- IDLE: on `tx_en`, capture `tx_awaddr` with its low `log2(BURST_LEN*DATA_W/8)` bits forced to 0, so a burst never crosses 4 KB. Capture `tx_awid`, drop `tx_rdy`, set `awvalid`, go to ADDR.
- ADDR: hold `awvalid` and the payload stable until `awready`. Then clear `awvalid`, set `wvalid`, go to DATA.
- DATA: on each `wvalid & wready`:
  - `tx_wdreq`=1 and the beat counter increments.
  - `wdata` = `tx_wdata` combinationally.
  - `wlast`=1 exactly on beat `BURST_LEN-1`; for `BURST_LEN`=1 it is high on the first beat.
  - After the last handshake, clear `wvalid`/`wlast` and go to RESP.
- RESP: see Configuration.
- Constant fields:
  - `awburst` = 2'b01 (INCR).
  - `awsize` = log2(`DATA_W`/8).
  - `wstrb` = all ones.
  - `wid` = captured `awid`.
  - `awlock`, `awprot`, `awqos` = 0.
- One burst in flight at a time; a `tx_en` seen while `tx_rdy`=0 is ignored.
- The FWFT source must hold valid data whenever `wvalid`=1. Underflow is not detected.
- Reset asserted mid-burst aborts immediately and returns to IDLE. The AXI protocol violation this causes is acceptable only because the PS interconnect is reset together with this block.

## Timing
All-ready case, request `tx_en` at cycle 0:
- Cycle 1: `awvalid`.
- Cycles 2..1+L: W beats, where L = `BURST_LEN`.
- Cycle 2+L: `bready`.
- Cycle 3+L: `tx_done` and `tx_rdy`.

Handshake rules:
- Each `awready` or `wready` stall adds exactly one cycle.
- `wvalid` never deasserts mid-burst.
- `tx_rdy` rises in the same cycle as `tx_done`. A new `tx_en` in that cycle is accepted, giving back-to-back bursts.

## Configuration
- `ACP_BRESP_CHECK_EN` defined:
  - RESP drives `bready`=1 until `bvalid`.
  - On the handshake, `tx_err` = (`bresp` != OKAY) | (`bid` != `awid`); `tx_done` pulses next cycle.
- `ACP_BRESP_CHECK_EN` undefined:
  - `bready` is tied 1 and RESP is skipped.
  - `tx_done`/`tx_rdy` occur the cycle after the last W handshake (latency 2+L).
  - `tx_err` is tied 0.

## Structure
- Package `ps_acp_pkg` holds:
  - burst constants `BURST_INCR` and `RESP_OKAY`;
  - the FSM state enum;
  - a `clog2` helper for `awsize` and address masking.
- One sub-module, `ps_acp_wbeat_gen`: beat counter, `wvalid`/`wlast` generation and the `tx_wdreq` strobe.

## Test plan
- `BURST_LEN`=16, all readies=1, `tx_awaddr`=0x1000_0000, `tx_awid`=3 -> `awlen`=15, `awsize`=3, 16 beats, `wlast` on beat 15, `tx_done` at cycle 19, `tx_err`=0.
- `awready` held 0 for 5 cycles, `wready` toggling 1/0 -> payload stable while stalled, exactly 16 pops, last `wdata` equals the 16th source word.
- `tx_awaddr`=0x0000_0F48 with `BURST_LEN`=16, `DATA_W`=64 -> `awaddr`=0x0000_0F00.
- With `ACP_BRESP_CHECK_EN`: `bresp`=2'b10 -> `tx_err`=1; `bid`=5 vs `awid`=3 -> `tx_err`=1; without the macro, same stimulus -> `tx_err`=0 and done at cycle 2+L.
- `BURST_LEN`=1, back-to-back `tx_en` held high -> `wlast` on every beat, consecutive bursts with no idle gap.
- `rst` pulsed during beat 7 -> `awvalid`/`wvalid`/`wlast` drop asynchronously, `tx_rdy`=1, and the next request completes normally.
